// File: rtl/stream_demux.sv
// One-to-two stream demultiplexer feeding two first-word-fallthrough FIFOs.
// Routing is either per packet (header DEST bit, held until TLAST) or per word.
module stream_demux #(
  parameter int unsigned DW          = 32,
  parameter bit          PACKET_MODE = 1'b1,
  parameter int unsigned TLAST_BIT   = DW - 1,
  parameter int unsigned DEST_BIT    = DW - 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          s00_tvalid,
  output logic          s00_tready,
  input  logic [DW-1:0] s00_tdata,
  output logic          m00_tvalid,
  input  logic          m00_tready,
  output logic [DW-1:0] m00_tdata,
  output logic [15:0]   m00_pkt_count,
  output logic          m01_tvalid,
  input  logic          m01_tready,
  output logic [DW-1:0] m01_tdata,
  output logic [15:0]   m01_pkt_count,
  output logic          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_mem [2][FIFO_DEPTH];
  logic [AW:0]   r_wptr [2];
  logic [AW:0]   r_rptr [2];
  logic [15:0]   r_pkt_count [2];
  logic [1:0]    w_full;
  logic [1:0]    w_empty;
  logic [1:0]    w_pop;
  logic [1:0]    w_wr;
  logic [1:0]    w_tready_m;
  logic          w_target;
  logic          w_push;
  logic          w_last;
  logic          w_dest;

  assign w_last     = s00_tdata[TLAST_BIT];
  assign w_dest     = s00_tdata[DEST_BIT];
  assign w_tready_m = {m01_tready, m00_tready};

  // The extra wrap bit separates full (same index, other lap) from empty.
  for (genvar g = 0; g < 2; g++) begin : g_flags
    assign w_empty[g] = (r_wptr[g] == r_rptr[g]);
    assign w_full[g]  = (r_wptr[g][AW-1:0] == r_rptr[g][AW-1:0]) &&
                        (r_wptr[g][AW] != r_rptr[g][AW]);
    assign w_pop[g]   = w_tready_m[g] & ~w_empty[g];
  end

  // Destination of the word currently on the input.
  always_comb begin
    w_target = w_dest;
    case (r_state)
      IDLE:    w_target = w_dest;
      ROUTE0:  w_target = 1'b0;
      ROUTE1:  w_target = 1'b1;
      default: w_target = w_dest;
    endcase
  end

  assign s00_tready = ~w_full[w_target];
  assign w_push     = s00_tvalid & s00_tready & ~areset;
  assign w_wr       = {w_push & w_target, w_push & ~w_target};

  // Router next-state: a header without TLAST opens a packet, TLAST closes it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (PACKET_MODE && w_push && !w_last) begin
          w_state_next = w_dest ? ROUTE1 : ROUTE0;
        end else begin
          w_state_next = IDLE;
        end
      end
      ROUTE0, ROUTE1: begin
        if (w_push && w_last) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = r_state;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Router state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FIFO pointers and per-output packet counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i]      <= PTR_ZERO;
        r_rptr[i]      <= PTR_ZERO;
        r_pkt_count[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_wr[i]) begin
          r_wptr[i] <= r_wptr[i] + PTR_ONE;
          if (w_last) begin
            r_pkt_count[i] <= r_pkt_count[i] + 16'd1;
          end
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_ONE;
        end
      end
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[w_target][r_wptr[w_target][AW-1:0]] <= s00_tdata;
    end
  end

  assign m00_tvalid    = ~w_empty[0];
  assign m01_tvalid    = ~w_empty[1];
  assign m00_tdata     = r_mem[0][r_rptr[0][AW-1:0]];
  assign m01_tdata     = r_mem[1][r_rptr[1][AW-1:0]];
  assign m00_pkt_count = r_pkt_count[0];
  assign m01_pkt_count = r_pkt_count[1];
  assign busy          = (r_state == ROUTE0) || (r_state == ROUTE1);

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a packet-mode and a word-mode instance share the
// same stimulus; a queue-based model checks both every cycle.
module tb_stream_demux;

  logic        aclk;
  logic        areset;
  logic        s_valid;
  logic [31:0] s_data;
  logic [1:0]  m_rdy;
  logic [1:0]  s_ready;
  logic [1:0]  busy;
  logic        mv   [2][2];
  logic [31:0] md   [2][2];
  logic [15:0] mcnt [2][2];

  int checks;
  int failures;

  // Model state: [dut][output] FIFO contents, lengths and packet counts.
  logic [31:0] mq [2][2][40];
  int          mn [2][2];
  logic [15:0] mc [2][2];
  bit          inpkt [2];
  bit          pdest [2];
  bit          live;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  stream_demux #(.PACKET_MODE(1'b1)) u_pkt (
    .aclk(aclk), .areset(areset),
    .s00_tvalid(s_valid), .s00_tready(s_ready[0]), .s00_tdata(s_data),
    .m00_tvalid(mv[0][0]), .m00_tready(m_rdy[0]), .m00_tdata(md[0][0]),
    .m00_pkt_count(mcnt[0][0]),
    .m01_tvalid(mv[0][1]), .m01_tready(m_rdy[1]), .m01_tdata(md[0][1]),
    .m01_pkt_count(mcnt[0][1]),
    .busy(busy[0])
  );

  stream_demux #(.PACKET_MODE(1'b0)) u_word (
    .aclk(aclk), .areset(areset),
    .s00_tvalid(s_valid), .s00_tready(s_ready[1]), .s00_tdata(s_data),
    .m00_tvalid(mv[1][0]), .m00_tready(m_rdy[0]), .m00_tdata(md[1][0]),
    .m00_pkt_count(mcnt[1][0]),
    .m01_tvalid(mv[1][1]), .m01_tready(m_rdy[1]), .m01_tdata(md[1][1]),
    .m01_pkt_count(mcnt[1][1]),
    .busy(busy[1])
  );

  function automatic logic [31:0] wd(input logic last, input logic dest, input logic [29:0] pl);
    return {last, dest, pl};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%h expected=%h time=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Compare outputs against the model, then advance the model over the next edge.
  always @(negedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      logic tgt;
      logic exp_rdy;
      logic acc;
      tgt     = (inpkt[k]) ? pdest[k] : s_data[30];
      exp_rdy = (mn[k][tgt] < 16);
      if (live) begin
        chk("s00_tready", k, {31'd0, s_ready[k]}, {31'd0, exp_rdy});
        chk("busy", k, {31'd0, busy[k]}, {31'd0, inpkt[k]});
        for (int f = 0; f < 2; f++) begin
          chk("tvalid", k, {31'd0, mv[k][f]}, {31'd0, (mn[k][f] > 0)});
          if (mn[k][f] > 0) chk("tdata", k, md[k][f], mq[k][f][0]);
          chk("pkt_count", k, {16'd0, mcnt[k][f]}, {16'd0, mc[k][f]});
        end
      end
      if (areset) begin
        mn[k][0] = 0; mn[k][1] = 0;
        mc[k][0] = 16'd0; mc[k][1] = 16'd0;
        inpkt[k] = 1'b0; pdest[k] = 1'b0;
      end else if (live) begin
        acc = s_valid && exp_rdy;
        for (int f = 0; f < 2; f++) begin
          if (m_rdy[f] && mn[k][f] > 0) begin
            for (int j = 0; j < 39; j++) mq[k][f][j] = mq[k][f][j+1];
            mn[k][f] = mn[k][f] - 1;
          end
        end
        if (acc) begin
          mq[k][tgt][mn[k][tgt]] = s_data;
          mn[k][tgt] = mn[k][tgt] + 1;
          if (s_data[31]) mc[k][tgt] = mc[k][tgt] + 16'd1;
          if (k == 0) begin
            if (!inpkt[k] && !s_data[31]) begin
              inpkt[k] = 1'b1;
              pdest[k] = s_data[30];
            end else if (inpkt[k] && s_data[31]) begin
              inpkt[k] = 1'b0;
            end
          end
        end
      end
    end
    if (areset) live = 1'b1;
  end

  // Present one input word for one cycle; rdy is the packet DUT's pre-edge tready.
  task automatic offer(input logic v, input logic [31:0] d, output logic rdy);
    s_valid = v;
    s_data  = d;
    #1;
    rdy = s_ready[0];
    @(posedge aclk);
    #2;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) offer(1'b0, 32'd0, r);
  endtask

  task automatic do_reset();
    areset  = 1'b1;
    s_valid = 1'b1;
    s_data  = wd(1'b0, 1'b1, 30'h3);
    @(posedge aclk);
    #2;
    chk("tready_in_reset", 0, {31'd0, s_ready[0]}, 32'd1);
    @(posedge aclk);
    #2;
    areset  = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    logic r;
    int   n;
    int   cyc;
    checks = 0; failures = 0; live = 1'b0;
    areset = 1'b1; s_valid = 1'b0; s_data = 32'd0; m_rdy = 2'b11;
    repeat (3) @(posedge aclk);
    #2;
    areset = 1'b0;
    chk("reset_m00_tvalid", 0, {31'd0, mv[0][0]}, 32'd0);
    chk("reset_m01_tvalid", 0, {31'd0, mv[0][1]}, 32'd0);
    chk("reset_busy", 0, {31'd0, busy[0]}, 32'd0);
    chk("reset_count", 0, {16'd0, mcnt[0][1]}, 32'd0);

    // 3-word packet to m01, body DEST bits mixed
    m_rdy = 2'b00;
    offer(1'b1, wd(1'b0, 1'b1, 30'h0A), r);
    chk("pkt3_busy_w2", 0, {31'd0, busy[0]}, 32'd1);
    chk("pkt3_head", 0, md[0][1], 32'h4000_000A);
    offer(1'b1, wd(1'b0, 1'b0, 30'h0B), r);
    chk("pkt3_busy_w3", 0, {31'd0, busy[0]}, 32'd1);
    offer(1'b1, wd(1'b1, 1'b1, 30'h0C), r);
    chk("pkt3_busy_end", 0, {31'd0, busy[0]}, 32'd0);
    chk("pkt3_count", 0, {16'd0, mcnt[0][1]}, 32'd1);
    chk("pkt3_m00_idle", 0, {31'd0, mv[0][0]}, 32'd0);
    m_rdy = 2'b11;
    idle(4);

    // back-to-back single-word packets alternating destination
    do_reset();
    offer(1'b1, wd(1'b1, 1'b0, 30'h1), r);
    chk("alt_w1", 0, md[0][0], 32'h8000_0001);
    offer(1'b1, wd(1'b1, 1'b1, 30'h2), r);
    chk("alt_w2", 0, md[0][1], 32'hC000_0002);
    chk("alt_w1_popped", 0, {31'd0, mv[0][0]}, 32'd0);
    offer(1'b1, wd(1'b1, 1'b0, 30'h3), r);
    offer(1'b1, wd(1'b1, 1'b1, 30'h4), r);
    idle(2);
    chk("alt_cnt0", 0, {16'd0, mcnt[0][0]}, 32'd2);
    chk("alt_cnt1", 0, {16'd0, mcnt[0][1]}, 32'd2);

    // 20-word packet into a stalled m00
    do_reset();
    m_rdy = 2'b10;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      offer(1'b1, wd((n == 19), 1'b0, 30'h100 + 30'(n)), r);
      if (r) n++;
    end
    chk("stall_accepted", 0, n, 32'd16);
    chk("stall_tready_low", 0, {31'd0, s_ready[0]}, 32'd0);
    chk("stall_head", 0, md[0][0], 32'h0000_0100);
    m_rdy = 2'b11;
    cyc = 0;
    while (n < 20 && cyc < 60) begin
      offer(1'b1, wd((n == 19), 1'b0, 30'h100 + 30'(n)), r);
      if (r) n++;
      cyc++;
    end
    chk("stall_all_accepted", 0, n, 32'd20);
    idle(24);
    chk("stall_count", 0, {16'd0, mcnt[0][0]}, 32'd1);

    // m00 full and stalled while m01 keeps flowing
    do_reset();
    m_rdy = 2'b10;
    for (int i = 0; i < 16; i++) offer(1'b1, wd(1'b1, 1'b0, 30'h200 + 30'(i)), r);
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, wd(1'b1, 1'b1, 30'h300 + 30'(i)), r);
      chk("indep_m01_ready", 0, {31'd0, r}, 32'd1);
    end
    idle(1);
    chk("indep_cnt1", 0, {16'd0, mcnt[0][1]}, 32'd3);
    chk("indep_m00_full", 0, {16'd0, mcnt[0][0]}, 32'd16);
    m_rdy = 2'b11;
    idle(18);

    // reset in the middle of a packet to m01
    do_reset();
    m_rdy = 2'b00;
    offer(1'b1, wd(1'b0, 1'b1, 30'h41), r);
    offer(1'b1, wd(1'b0, 1'b1, 30'h42), r);
    do_reset();
    chk("midrst_m01_empty", 0, {31'd0, mv[0][1]}, 32'd0);
    chk("midrst_m00_empty", 0, {31'd0, mv[0][0]}, 32'd0);
    chk("midrst_busy", 0, {31'd0, busy[0]}, 32'd0);
    offer(1'b1, wd(1'b0, 1'b0, 30'h43), r);
    chk("midrst_new_head", 0, md[0][0], 32'h0000_0043);
    chk("midrst_new_busy", 0, {31'd0, busy[0]}, 32'd1);
    offer(1'b1, wd(1'b1, 1'b1, 30'h44), r);
    chk("midrst_cnt0", 0, {16'd0, mcnt[0][0]}, 32'd1);
    chk("midrst_m01_still", 0, {31'd0, mv[0][1]}, 32'd0);
    m_rdy = 2'b11;
    idle(4);

    // word mode routes per word and never reports busy
    do_reset();
    m_rdy = 2'b00;
    offer(1'b1, wd(1'b0, 1'b1, 30'h51), r);
    offer(1'b1, wd(1'b0, 1'b0, 30'h52), r);
    offer(1'b1, wd(1'b0, 1'b1, 30'h53), r);
    chk("word_busy", 1, {31'd0, busy[1]}, 32'd0);
    chk("word_m00", 1, md[1][0], 32'h0000_0052);
    chk("word_m01", 1, md[1][1], 32'h4000_0051);
    chk("word_pkt_m00", 0, {31'd0, mv[0][0]}, 32'd0);
    m_rdy = 2'b11;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DW, default 32: width of every tdata port.
REQ-002 Parameter PACKET_MODE, default 1'b1: 1 = route whole packets (header-selected, held until TLAST); 0 = route every word independently.
REQ-003 Parameter TLAST_BIT, default DW-1: bit of tdata marking the last word of a packet.
REQ-004 Parameter DEST_BIT, default DW-2: bit of tdata selecting the destination (0 -> m00, 1 -> m01).
REQ-005 Parameter FIFO_DEPTH, default 16: words per output FIFO; SHALL be a power of 2, minimum 2.
REQ-006 aclk  input  1  single clock for all logic.
REQ-007 areset  input  1  synchronous, active-high reset.
REQ-008 s00_tvalid  input  1  input word valid.
REQ-009 s00_tready  output  1  input word accepted when s00_tvalid & s00_tready at a rising edge of aclk.
REQ-010 s00_tdata  input  DW  input word, carrying TLAST_BIT and DEST_BIT in-band.
REQ-011 m00_tvalid / m01_tvalid  output  1  each: output FIFO not empty.
REQ-012 m00_tready / m01_tready  input  1  each: downstream pop enable.
REQ-013 m00_tdata / m01_tdata  output  DW  each: FIFO head word (first-word-fallthrough), forwarded unmodified.
REQ-014 m00_pkt_count / m01_pkt_count  output  16  each: words with TLAST_BIT=1 written into that FIFO, wrapping modulo 2^16.
REQ-015 busy  output  1  high while the router is in state ROUTE0 or ROUTE1.

Function
REQ-016 Two independent FWFT FIFOs of FIFO_DEPTH words; pointers carry one extra wrap bit; full = equal index with differing wrap bit; empty = equal pointers.
REQ-017 Router FSM states: IDLE, ROUTE0, ROUTE1; target = s00_tdata[DEST_BIT] in IDLE (and always when PACKET_MODE=0), 0 in ROUTE0, 1 in ROUTE1.
REQ-018 s00_tready SHALL be combinational: ~full of the target FIFO; the non-target FIFO's state has no effect.
REQ-019 An accepted word SHALL be written to the target FIFO at that edge; no word is ever dropped or duplicated.
REQ-020 PACKET_MODE=1, IDLE: accepted word with TLAST_BIT=0 -> ROUTE0/ROUTE1 per DEST_BIT; TLAST_BIT=1 (single-word packet) -> remain IDLE.
REQ-021 ROUTE0/ROUTE1: DEST_BIT of body words ignored; accepted word with TLAST_BIT=1 -> IDLE; otherwise hold state.
REQ-022 PACKET_MODE=0: FSM stays in IDLE; busy stays 0; m*_pkt_count still counts TLAST_BIT words.
REQ-023 Latency: word accepted at edge N SHALL appear on m0x_tdata with m0x_tvalid=1 immediately after edge N when that FIFO was empty.
REQ-024 Pop: m0x_tvalid & m0x_tready at an edge advances that FIFO's read pointer; m0x_tready while empty has no effect.
REQ-025 Simultaneous push and pop on the same FIFO SHALL both occur; a full FIFO popped in a cycle still deasserts s00_tready that cycle (full evaluated on current pointers).
REQ-026 A stalled FIFO (full) SHALL NOT block the other output from draining.
REQ-027 Pointer and counter wrap-around SHALL be modulo arithmetic with no glitch in full/empty.

Reset
REQ-028 areset high at an edge: both FIFOs emptied, FSM -> IDLE, m00_tvalid=m01_tvalid=0, busy=0, both pkt_counts=0; FIFO RAM contents need not be cleared.
REQ-029 Reset mid-packet SHALL discard the partial packet; the next accepted word is treated as a header.
REQ-030 While areset is high, s00_tready is driven as after reset (1 if target FIFO empty); words accepted during reset are discarded.

Verification
REQ-031 PACKET_MODE=1: 3-word packet, header DEST_BIT=1, body DEST_BIT=0/1 mixed, TLAST on word 3 -> all 3 words on m01 in order, m01_pkt_count=1, m00 idle, busy high for words 2-3 only.
REQ-032 Back-to-back single-word packets DEST 0,1,0,1 with both treadys high -> alternate outputs, each word visible one edge after acceptance, pkt_counts 2/2.
REQ-033 m00_tready=0, FIFO_DEPTH=16, stream 20 words to m00 -> s00_tready falls after 16th word, no loss; release m00_tready -> all 20 words emerge in order.
REQ-034 m00 full and stalled, headers to m01 -> m01 traffic flows unimpeded.
REQ-035 areset pulsed after word 2 of a 4-word packet to m01 -> both outputs empty, counts 0; next word with DEST_BIT=0 routes to m00.
REQ-036 PACKET_MODE=0: words DEST 1,0,1 with TLAST=0 -> routed per word; busy stays 0.
